// File: rtl/sp_pkg.sv
// Shared types and constants for the PCI lane sync controller.
package sp_pkg;

    localparam logic [7:0] COMMA_BC = 8'hBC;
    localparam int         BCW      = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sp_state_e;

endpackage

// File: rtl/sp_shift_phase.sv
// Serial shift register and bit-phase counter that stands in
// for the separate byte clock.
module sp_shift_phase
    import sp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       data_i,
    input  logic       clr_i,
    output logic [7:0] nxt_o,
    output logic       boundary_o
);

    logic [7:0]     sr_q;
    logic [BCW-1:0] bit_cnt_q;

    assign nxt_o      = {sr_q[6:0], data_i};
    assign boundary_o = (bit_cnt_q == '1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q <= nxt_o;
            if (clr_i) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_sync_ctrl.sv
// Comma-hunting byte aligner and lane-sync FSM on the bit clock.
// Emits aligned data bytes with a valid flag and a byte strobe.
module sp_sync_ctrl
    import sp_pkg::*;
#(
    parameter logic [7:0] COMMA   = COMMA_BC,
    parameter int         N_LOCK  = 4,
    parameter int         MAX_GAP = 64
) (
    input  logic                        clk_32f,
    input  logic                        reset,
    input  logic                        data_in,
    output logic [7:0]                  data_out,
    output logic                        valid_out,
    output logic                        active,
    output logic                        byte_tick,
    output logic [$clog2(N_LOCK+1)-1:0] comma_cnt_o
);

    localparam int CW = $clog2(N_LOCK + 1);
    localparam int GW = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    sp_state_e   state_q, state_d;
    logic [CW-1:0] comma_q, comma_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        tick_q, tick_d;

    logic [7:0]  nxt;
    logic        boundary;
    logic        clr;
    logic        is_comma;

    sp_shift_phase u_phase (
        .clk_i      (clk_32f),
        .rst_ni     (reset),
        .data_i     (data_in),
        .clr_i      (clr),
        .nxt_o      (nxt),
        .boundary_o (boundary)
    );

    assign is_comma = (nxt == COMMA);

    always_comb begin
        state_d = state_q;
        comma_d = comma_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = valid_q;
        tick_d  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (is_comma) begin
                    clr     = 1'b1;
                    comma_d = CW'(1);
                    gap_d   = '0;
                    state_d = (N_LOCK == 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (boundary) begin
                    tick_d = 1'b1;
                    if (is_comma) begin
                        comma_d = comma_q + 1'b1;
                        if (comma_q == CW'(N_LOCK - 1)) begin
                            state_d = LOCKED;
                            gap_d   = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        comma_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    tick_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
                        gap_d   = '0;
                    end else if (MAX_GAP != 0 &&
                                 int'(gap_q) + 1 == MAX_GAP) begin
                        // Sync lost: drop the byte, restart hunt
                        state_d = HUNT;
                        valid_d = 1'b0;
                        comma_d = '0;
                    end else begin
                        data_d  = nxt;
                        valid_d = 1'b1;
                        if (gap_q != '1) begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            comma_q <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            comma_q <= comma_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tick_q  <= tick_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = (state_q == LOCKED);
    assign byte_tick   = tick_q;
    assign comma_cnt_o = comma_q;

endmodule

// File: tb/tb_sp_sync_ctrl.sv
// Randomized bench for sp_sync_ctrl against a bit-history model,
// run on a default instance and one with a short gap limit.
module tb_sp_sync_ctrl;

    localparam int NL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic [7:0] dout [2];
    logic       vld  [2];
    logic       act  [2];
    logic       tick [2];
    logic [2:0] ccnt [2];

    int n_chk = 0;
    int n_fail = 0;
    int edges = 0;

    always #5 clk = ~clk;

    sp_sync_ctrl u_dut (
        .clk_32f     (clk),
        .reset       (rst_n),
        .data_in     (din),
        .data_out    (dout[0]),
        .valid_out   (vld[0]),
        .active      (act[0]),
        .byte_tick   (tick[0]),
        .comma_cnt_o (ccnt[0])
    );

    sp_sync_ctrl #(.MAX_GAP(4)) u_dut_g4 (
        .clk_32f     (clk),
        .reset       (rst_n),
        .data_in     (din),
        .data_out    (dout[1]),
        .valid_out   (vld[1]),
        .active      (act[1]),
        .byte_tick   (tick[1]),
        .comma_cnt_o (ccnt[1])
    );

    // Reference model: mode 0 hunting, 1 confirming, 2 locked.
    int         lim [2] = '{64, 4};
    logic [7:0] m_hist;
    int         m_mode [2];
    int         m_since [2];
    int         m_commas [2];
    int         m_gap [2];
    int         m_data [2];
    int         m_valid [2];
    int         m_tick [2];

    task automatic check_eq(string tag, int obs, int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_mode[k]   = 0;
            m_since[k]  = 0;
            m_commas[k] = 0;
            m_gap[k]    = 0;
            m_data[k]   = 0;
            m_valid[k]  = 0;
            m_tick[k]   = 0;
        end
    endtask

    task automatic model_step(logic b);
        logic c;
        m_hist = {m_hist[6:0], b};
        c = (m_hist == 8'hBC);
        for (int k = 0; k < 2; k++) begin
            m_tick[k] = 0;
            if (m_mode[k] == 0) begin
                if (c) begin
                    m_commas[k] = 1;
                    m_since[k]  = 0;
                    m_gap[k]    = 0;
                    m_mode[k]   = (NL == 1) ? 2 : 1;
                end
            end else begin
                m_since[k]++;
                if (m_since[k] % 8 == 0) begin
                    m_tick[k] = 1;
                    if (m_mode[k] == 1) begin
                        if (c) begin
                            m_commas[k]++;
                            if (m_commas[k] == NL) begin
                                m_mode[k] = 2;
                                m_gap[k]  = 0;
                            end
                        end else begin
                            m_mode[k]   = 0;
                            m_commas[k] = 0;
                        end
                    end else if (c) begin
                        m_valid[k] = 0;
                        m_gap[k]   = 0;
                    end else if (lim[k] != 0 &&
                                 m_gap[k] + 1 == lim[k]) begin
                        m_mode[k]   = 0;
                        m_valid[k]  = 0;
                        m_commas[k] = 0;
                    end else begin
                        m_data[k]  = int'(m_hist);
                        m_valid[k] = 1;
                        m_gap[k]++;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("u%0d.data", k),
                     int'(dout[k]), m_data[k]);
            check_eq($sformatf("u%0d.valid", k),
                     int'(vld[k]), m_valid[k]);
            check_eq($sformatf("u%0d.active", k),
                     int'(act[k]), int'(m_mode[k] == 2));
            check_eq($sformatf("u%0d.tick", k),
                     int'(tick[k]), m_tick[k]);
            check_eq($sformatf("u%0d.ccnt", k),
                     int'(ccnt[k]), m_commas[k]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic send_bit(logic b);
        din = b;
        @(posedge clk);
        edges++;
        model_step(b);
        #1;
        compare_all();
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_commas(int n);
        for (int i = 0; i < n; i++) begin
            send_byte(8'hBC);
        end
    endtask

    initial begin
        int act_edge;
        rst_n = 1'b0;
        din   = 1'b0;
        do_reset();

        // 1: aligned lock from the first bit
        act_edge = -1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 7; j >= 0; j--) begin
                logic [7:0] cm;
                cm = 8'hBC;
                send_bit(cm[j]);
                if (act[0] && act_edge < 0) begin
                    act_edge = edges;
                end
            end
        end
        check_eq("lock_edge", act_edge, 32);

        // 2: junk bits then lock on an offset boundary
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_commas(4);
        send_byte(8'h55);
        check_eq("s2_data55", int'(dout[0]), 8'h55);
        send_byte(8'hA3);
        check_eq("s2_dataA3", int'(dout[0]), 8'hA3);

        // 3: aborted confirmation, then relock
        do_reset();
        send_commas(2);
        send_byte(8'h7C);
        check_eq("s3_ccnt0", int'(ccnt[0]), 0);
        send_commas(4);
        check_eq("s3_active", int'(act[0]), 1);

        // 4: commas between data bytes while locked
        send_byte(8'h12);
        send_byte(8'hBC);
        check_eq("s4_hold", int'(dout[0]), 8'h12);
        send_byte(8'h34);
        send_byte(8'hBC);

        // 5: gap limit on the short-gap instance
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check_eq("s5_g4_act", int'(act[1]), 0);
        check_eq("s5_g4_data", int'(dout[1]), 8'h33);
        check_eq("s5_main_act", int'(act[0]), 1);

        // 6: mid-byte reset while locked, then relock
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        do_reset();
        send_commas(4);
        check_eq("s6_relock", int'(act[0]), 1);

        // Random traffic with occasional resets
        for (int it = 0; it < 20; it++) begin
            int junk;
            if ($urandom_range(0, 3) == 0) begin
                do_reset();
            end
            junk = $urandom_range(0, 7);
            for (int i = 0; i < junk; i++) begin
                send_bit(1'($urandom_range(0, 1)));
            end
            send_commas(4);
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    send_byte(8'hBC);
                end else begin
                    send_byte(8'($urandom_range(0, 255)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
